// File: rtl/serial_cmp_pkg.sv
// -----------------------------------------------------------------------------
// serial_cmp_pkg
//   Shared types and constants for the bit-serial magnitude comparator.
//   - state_t : sequencer state encoding (IDLE, SHIFT, DONE)
//   - RES_*   : one-hot {gt, eq, lt} result encodings
// -----------------------------------------------------------------------------
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] RES_GT = 3'b100;
    localparam logic [2:0] RES_EQ = 3'b010;
    localparam logic [2:0] RES_LT = 3'b001;

endpackage : serial_cmp_pkg

// File: rtl/serial_mag_comp_comp1.sv
// -----------------------------------------------------------------------------
// comp1
//   1-bit magnitude comparator cell.
//   Ports:
//     a, b : input bits
//     o1   : a > b
//     o2   : a == b
//     o3   : a < b
//   Exactly one of o1/o2/o3 is high for any input pair.
// -----------------------------------------------------------------------------
module comp1 (
    input  logic a,
    input  logic b,
    output logic o1,
    output logic o2,
    output logic o3
);

    assign o1 = a & ~b;
    assign o2 = ~(a ^ b);
    assign o3 = ~a & b;

endmodule : comp1

// File: rtl/serial_mag_comp.sv
// -----------------------------------------------------------------------------
// serial_mag_comp
//   Bit-serial unsigned magnitude comparator. Captures two WIDTH-bit operands
//   on an accepted start, feeds one bit pair per clock (MSB first) through a
//   single comp1 cell, and latches the first difference it sees. Publishes a
//   one-hot gt/eq/lt result together with a one-cycle done pulse.
//
//   Parameters:
//     WIDTH  operand width in bits (2..64)
//
//   Ports:
//     clk    system clock, rising edge
//     rst    synchronous, active-high reset
//     start  request, honoured only when idle and not busy
//     a, b   operands, captured on accept
//     busy   high from the cycle after accept through the done cycle
//     done   one-cycle pulse, result valid
//     gt/eq/lt  one-hot result, held until the next accepted start
//
//   Build option:
//     SERIAL_CMP_EARLY_EXIT_EN  when defined, the sequencer leaves SHIFT on
//     the first differing bit instead of always running WIDTH cycles.
// -----------------------------------------------------------------------------
module serial_mag_comp
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CW-1:0]    cnt;
    logic             decided;
    logic             gt_r;
    logic             lt_r;

    logic             o1;
    logic             o2;
    logic             o3;
    logic             decide_gt;
    logic             decide_lt;
    logic             last_bit;
    logic             exit_shift;
    logic [2:0]       res;

    comp1 u_comp1 (
        .a  (a_sh[WIDTH-1]),
        .b  (b_sh[WIDTH-1]),
        .o1 (o1),
        .o2 (o2),
        .o3 (o3)
    );

    // NOTE: every always_comb output is given a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        decide_gt  = 1'b0;
        decide_lt  = 1'b0;
        last_bit   = 1'b0;
        exit_shift = 1'b0;
        res        = RES_EQ;

        decide_gt = !decided && o1;
        decide_lt = !decided && o3;
        last_bit  = (cnt == CW'(1));
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        exit_shift = last_bit || decide_gt || decide_lt;
`else
        exit_shift = last_bit;
`endif
        if (gt_r)      res = RES_GT;
        else if (lt_r) res = RES_LT;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            a_sh         <= '0;
            b_sh         <= '0;
            cnt          <= '0;
            decided      <= 1'b0;
            gt_r         <= 1'b0;
            lt_r         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            {gt, eq, lt} <= 3'b000;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // busy is still high during the done cycle; a start seen
                    // there is ignored like any other start while busy.
                    if (start && !busy) begin
                        a_sh         <= a;
                        b_sh         <= b;
                        cnt          <= CW'(WIDTH);
                        decided      <= 1'b0;
                        gt_r         <= 1'b0;
                        lt_r         <= 1'b0;
                        {gt, eq, lt} <= 3'b000;
                        busy         <= 1'b1;
                        state        <= SHIFT;
                    end else begin
                        busy <= 1'b0;
                    end
                end

                SHIFT: begin
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh << 1;
                    cnt  <= cnt - CW'(1);
                    // The first differing bit from the MSB decides; later
                    // bits cannot change an unsigned comparison.
                    if (decide_gt) begin
                        gt_r    <= 1'b1;
                        decided <= 1'b1;
                    end
                    if (decide_lt) begin
                        lt_r    <= 1'b1;
                        decided <= 1'b1;
                    end
                    if (exit_shift) state <= DONE;
                end

                DONE: begin
                    done         <= 1'b1;
                    {gt, eq, lt} <= res;
                    state        <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    // The cell's equality output is redundant with the other two.
    assert property (@(posedge clk) disable iff (rst) o2 == !(o1 | o3));

    // A published result is always one-hot.
    assert property (@(posedge clk) disable iff (rst) done |-> $onehot({gt, eq, lt}));

endmodule : serial_mag_comp

// File: tb/tb_serial_mag_comp.sv
// -----------------------------------------------------------------------------
// tb_serial_mag_comp
//   Directed bench for serial_mag_comp (WIDTH=8). Stimulus pushes the
//   hand-computed result and done edge into a scoreboard; a negedge monitor
//   pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_serial_mag_comp;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    localparam logic [2:0] E_GT = 3'b100;
    localparam logic [2:0] E_EQ = 3'b010;
    localparam logic [2:0] E_LT = 3'b001;

    typedef struct {
        logic [2:0] res;
        int         done_edge;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       busy;
    logic       done;
    logic       gt;
    logic       eq;
    logic       lt;

    int   edge_cnt = 0;
    int   n_tests  = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    logic prev_done = 1'b0;
    logic [2:0] last_res = 3'b000;

    serial_mag_comp #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .gt    (gt),
        .eq    (eq),
        .lt    (lt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (done) begin
            check("done_single_cycle", {31'd0, prev_done}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", {29'd0, gt, eq, lt}, {29'd0, e.res});
                check("done_edge", edge_cnt, e.done_edge);
                check("busy_in_done", {31'd0, busy}, 32'd1);
            end
        end
        prev_done = done;
    end

    // Accept one start at the next edge; optionally register an expectation.
    task automatic issue(input logic [7:0] va, input logic [7:0] vb,
                         input logic [2:0] res, input int lat_fixed,
                         input int lat_early, input bit expect_done);
        exp_t e;
        @(negedge clk);
        a = va;
        b = vb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (expect_done) begin
            e.res       = res;
            e.done_edge = edge_cnt + (EARLY ? lat_early : lat_fixed);
            sb.push_back(e);
            last_res = res;
        end
        // Operands are free to change once accepted.
        a = ~va;
        b = ~vb;
    endtask

    // Wait (bounded) for all expectations to drain, then confirm the result
    // is held and the block has gone idle.
    task automatic wait_idle();
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            check("done_timeout", sb.size(), 32'd0);
            sb.delete();
        end
        @(negedge clk);
        #1;
        check("post_done_idle", {29'd0, busy, done, 1'b0}, 32'd0);
        check("result_held", {29'd0, gt, eq, lt}, {29'd0, last_res});
    endtask

    initial begin
        // 1. Reset state, then equal operands.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {27'd0, busy, done, gt, eq, lt}, 32'd0);
        rst = 1'b0;

        issue(8'hA5, 8'hA5, E_EQ, 9, 9, 1'b1);
        wait_idle();

        // 2. Differ at MSB.
        issue(8'h80, 8'h7F, E_GT, 9, 2, 1'b1);
        wait_idle();

        // 3. Differ only at LSB.
        issue(8'h12, 8'h13, E_LT, 9, 9, 1'b1);
        wait_idle();

        // 4. Boundaries.
        issue(8'h00, 8'hFF, E_LT, 9, 2, 1'b1);
        wait_idle();
        issue(8'hFF, 8'h00, E_GT, 9, 2, 1'b1);
        wait_idle();
        issue(8'h00, 8'h00, E_EQ, 9, 9, 1'b1);
        wait_idle();

        // 5. Start while busy is ignored.
        issue(8'h3C, 8'h3D, E_LT, 9, 9, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("busy_in_shift", {31'd0, busy}, 32'd1);
        check("results_cleared", {29'd0, gt, eq, lt}, 32'd0);
        a = 8'hFF;
        b = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (12) @(negedge clk);
        check("no_extra_done", sb.size(), 32'd0);

        // 6. Reset during SHIFT aborts without done.
        issue(8'h01, 8'h02, E_LT, 9, 8, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_outputs", {27'd0, busy, done, gt, eq, lt}, 32'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_no_done", {27'd0, busy, done, gt, eq, lt}, 32'd0);

        issue(8'hC3, 8'hC3, E_EQ, 9, 9, 1'b1);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule : tb_serial_mag_comp
